// File: rtl/pcpi_approx_simd_mul.sv
// PCPI co-processor: packed SIMD truncated unsigned multiply with lane packing,
// dot-product accumulate and a multi-cycle IDLE/CALC/DONE/COOL handshake.
module pcpi_approx_simd_mul #(
    parameter int LANE_W = 8,
    parameter int PAR    = 1,
    parameter int TRUNC  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);
    localparam int LANES = 32 / LANE_W;
    localparam int N     = LANES / PAR;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int PW    = 2 * LANE_W;

    typedef enum logic [1:0] {IDLE, CALC, DONE, COOL} state_t;

    state_t             state, state_nx;
    logic [2:0]         funct3_q;
    logic [31:0]        rs1_q, rs2_q;
    logic [IDX_W-1:0]   idx;
    logic [PW-1:0]      prod [LANES];
    logic [31:0]        acc, acc_nx, rd_q, rd_nx;
    logic [LANES*PW-1:0]     all_p;
    logic [LANES*LANE_W-1:0] lo_p, hi_p;
    logic [31:0]        psum;
    logic               claim, last;
    logic               unused_insn;

    // Partial products a_i*b_j whose column i+j falls below TRUNC are dropped.
    function automatic logic [PW-1:0] trunc_mul(input logic [LANE_W-1:0] a,
                                                input logic [LANE_W-1:0] b);
        logic [PW-1:0] s;
        s = '0;
        for (int i = 0; i < LANE_W; i++)
            for (int j = 0; j < LANE_W; j++)
                if ((i + j) >= TRUNC && a[i] && b[j])
                    s = s + (PW'(1) << (i + j));
        return s;
    endfunction

    assign claim = pcpi_valid && (pcpi_insn[6:0] == 7'b0001011)
                && (pcpi_insn[31:25] == 7'b0000011) && (pcpi_insn[14:12] <= 3'b100);
    assign last  = (idx == IDX_W'(N - 1));
    assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (claim) state_nx = CALC;
            CALC:    if (!pcpi_valid) state_nx = IDLE;
                     else if (last)   state_nx = DONE;
            DONE:    state_nx = COOL;
            COOL:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pcpi_wait  = (state == CALC);
        pcpi_ready = (state == DONE);
        pcpi_wr    = (state == DONE);
        pcpi_rd    = (state == DONE) ? rd_nx : rd_q;
    end

    // Control state: lane index, accumulator and held result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx  <= '0;
            acc  <= '0;
            rd_q <= '0;
        end else begin
            case (state)
                IDLE:    if (claim) idx <= '0;
                CALC:    idx <= idx + IDX_W'(1);
                DONE: begin
                    acc  <= acc_nx;
                    rd_q <= rd_nx;
                end
                default: ;
            endcase
        end
    end

    // Operand latch and PAR-lanes-per-cycle product file
    always_ff @(posedge clk) begin
        if (state == IDLE && claim) begin
            funct3_q <= pcpi_insn[14:12];
            rs1_q    <= pcpi_rs1;
            rs2_q    <= pcpi_rs2;
        end
        if (state == CALC)
            for (int k = 0; k < LANES; k++)
                if (IDX_W'(k / PAR) == idx)
                    prod[k] <= trunc_mul(rs1_q[k*LANE_W +: LANE_W], rs2_q[k*LANE_W +: LANE_W]);
    end

    always_comb begin
        all_p = '0;
        lo_p  = '0;
        hi_p  = '0;
        psum  = '0;
        for (int k = 0; k < LANES; k++) begin
            all_p[k*PW +: PW]         = prod[k];
            lo_p[k*LANE_W +: LANE_W]  = prod[k][LANE_W-1:0];
            hi_p[k*LANE_W +: LANE_W]  = prod[k][PW-1:LANE_W];
            psum                      = psum + 32'(prod[k]);
        end
        acc_nx = acc;
        rd_nx  = '0;
        case (funct3_q)
            3'b000: rd_nx = all_p[31:0];
            3'b001: rd_nx = lo_p;
            3'b010: rd_nx = hi_p;
            3'b011: begin
                rd_nx  = acc + psum;
                acc_nx = acc + psum;
            end
            3'b100: begin
                rd_nx  = acc;
                acc_nx = '0;
            end
            default: rd_nx = '0;
        endcase
    end
endmodule
